// File: rtl/ring_arb_pkg.sv
// ---------------------------------------------------------------------------
// ring_arb_pkg
// Shared definitions for the ring (round-robin) arbiter:
//   - FSM state encoding and the state enum used by ring_arbiter
//   - default requester count and maximum hold time
//   - rotl_onehot(): rotate a one-hot token left by one within n bits
// ---------------------------------------------------------------------------
package ring_arb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_GRANT = ST_GRANT,
      S_GAP   = ST_GAP
   } state_t;

   localparam int DEF_N        = 4;
   localparam int DEF_MAX_HOLD = 8;

   // Tokens are carried in an 8-bit container (N <= 8); bits above n are
   // masked off so the wrap from bit n-1 lands on bit 0.
   function automatic logic [7:0] rotl_onehot(input logic [7:0] v, input int n);
      logic [7:0] mask;
      mask = 8'hFF >> (8 - n);
      return ((v << 1) | (v >> (n - 1))) & mask;
   endfunction

endpackage

// File: rtl/ring_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin pick: first set request at or above the
// one-hot priority token, wrapping from N-1 back to 0.
// Ports:
//   i_req  [N-1:0]   request vector
//   i_ptr  [N-1:0]   one-hot priority token
//   o_win  [N-1:0]   one-hot winner (zero when no request)
//   o_id   [IDW-1:0] index of winner (zero when no request)
//   o_any            at least one request present
// ---------------------------------------------------------------------------
module rr_pick
   import ring_arb_pkg::*;
#(
   parameter int N   = DEF_N,
   parameter int IDW = $clog2(DEF_N)
) (
   input  logic [N-1:0]   i_req,
   input  logic [N-1:0]   i_ptr,
   output logic [N-1:0]   o_win,
   output logic [IDW-1:0] o_id,
   output logic           o_any
);

   // Lower half keeps only requests at or above the token; upper half is the
   // unmasked copy, so a plain bottom-up scan of 2N bits implements the wrap.
   logic [2*N-1:0] w_dbl;

   always_comb begin
      w_dbl = {i_req, i_req & ~(i_ptr - N'(1))};
      o_win = '0;
      o_id  = '0;
      o_any = 1'b0;
      for (int i = 0; i < 2 * N; i++) begin
         if (w_dbl[i] && !o_any) begin
            o_any          = 1'b1;
            o_win[i % N]   = 1'b1;
            o_id           = IDW'(i % N);
         end
      end
   end

endmodule

// File: rtl/ring_arbiter.sv
// ---------------------------------------------------------------------------
// ring_arbiter
// Round-robin arbiter for N requesters with a rotating one-hot token,
// registered one-hot grant, a one-cycle turnaround gap between grants and a
// maximum hold time enforced only while someone else is waiting.
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   req      [N-1:0] level requests, held until done
//   gnt      [N-1:0] registered one-hot grant, zero when idle
//   gnt_id   index of the granted requester, zero when no grant
//   busy     1 while any gnt bit is set
//   timeout  one-cycle pulse when a grant is revoked by MAX_HOLD
// ---------------------------------------------------------------------------
module ring_arbiter
   import ring_arb_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int MAX_HOLD = DEF_MAX_HOLD,
   parameter int CNT_W    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 busy,
   output logic                 timeout
);

   localparam int IDW = $clog2(N);

   state_t           r_state;
   logic [N-1:0]     r_ptr;
   logic [CNT_W-1:0] r_hold;
   logic [N-1:0]     r_gnt;
   logic [IDW-1:0]   r_gnt_id;
   logic             r_busy;
   logic             r_timeout;

   logic [N-1:0]     w_win;
   logic [IDW-1:0]   w_id;
   logic             w_any;
   logic             w_owner_req;
   logic             w_others_req;
   logic [N-1:0]     w_ptr_next;

   rr_pick #(
      .N   (N),
      .IDW (IDW)
   ) u_pick (
      .i_req (req),
      .i_ptr (r_ptr),
      .o_win (w_win),
      .o_id  (w_id),
      .o_any (w_any)
   );

   assign w_owner_req  = |(req & r_gnt);
   assign w_others_req = |(req & ~r_gnt);
   // Token moves to the position just past the current owner.
   assign w_ptr_next   = N'(rotl_onehot(8'(r_gnt), N));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_ptr     <= N'(1);
         r_hold    <= '0;
         r_gnt     <= '0;
         r_gnt_id  <= '0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            S_IDLE, S_GAP: begin
               if (w_any) begin
                  r_gnt    <= w_win;
                  r_gnt_id <= w_id;
                  r_busy   <= 1'b1;
                  r_hold   <= CNT_W'(1);
                  r_state  <= S_GRANT;
               end else begin
                  r_gnt    <= '0;
                  r_gnt_id <= '0;
                  r_busy   <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            S_GRANT: begin
               // A release wins over a simultaneous hold-limit hit, so the
               // release path is tested first and never raises timeout.
               if (!w_owner_req) begin
                  r_gnt    <= '0;
                  r_gnt_id <= '0;
                  r_busy   <= 1'b0;
                  r_ptr    <= w_ptr_next;
                  r_state  <= S_GAP;
               end else if (r_hold < CNT_W'(MAX_HOLD)) begin
                  r_hold   <= r_hold + CNT_W'(1);
               end else if (w_others_req) begin
                  r_gnt     <= '0;
                  r_gnt_id  <= '0;
                  r_busy    <= 1'b0;
                  r_timeout <= 1'b1;
                  r_ptr     <= w_ptr_next;
                  r_state   <= S_GAP;
               end
               // Sole requester at the limit: grant kept, counter saturated.
            end
            default: begin
               r_gnt    <= '0;
               r_gnt_id <= '0;
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt     = r_gnt;
   assign gnt_id  = r_gnt_id;
   assign busy    = r_busy;
   assign timeout = r_timeout;

endmodule
